// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory self-test sequencer: FSM state encoding,
// pattern selector values and the pattern generator.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  localparam logic PAT_INC = 1'b0;  // data = idx+1
  localparam logic PAT_INV = 1'b1;  // data = ~(idx+1)

  // Working width of the pattern generator; callers truncate to the RAM width.
  localparam int PAT_W = 32;

  // Pattern for one location, given idx+1 already formed by the caller.
  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] idx_p1,
                                               input logic             sel);
    logic [PAT_W-1:0] res;
    case (sel)
      PAT_INC: res = idx_p1;
      PAT_INV: res = ~idx_p1;
      default: res = idx_p1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_bist_rd_pipe.sv
// Read-expectation pipe: carries {valid, addr, expected} alongside each RAM read
// so that the output stage lines up with the dataR returned for that read.
module mem_bist_rd_pipe
  import mem_bist_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int ADD_WIDTH = 10,
  parameter int DAT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic [ADD_WIDTH-1:0] push_addr,
  input  logic [DAT_WIDTH-1:0] push_exp,
  output logic                 out_valid,
  output logic [ADD_WIDTH-1:0] out_addr,
  output logic [DAT_WIDTH-1:0] out_exp
);

  logic [RD_LAT-1:0]    vld_q;
  logic [ADD_WIDTH-1:0] addr_q [RD_LAT];
  logic [DAT_WIDTH-1:0] exp_q  [RD_LAT];

  // Valid bits: cleared on reset or flush, otherwise shifted one stage per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= push;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Payload shift register.
  // NOTE: payload has no reset; it is only ever consumed when its valid bit is set.
  always_ff @(posedge clk) begin
    addr_q[0] <= push_addr;
    exp_q[0]  <= push_exp;
    for (int i = 1; i < RD_LAT; i++) begin
      addr_q[i] <= addr_q[i-1];
      exp_q[i]  <= exp_q[i-1];
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];
  assign out_exp   = exp_q[RD_LAT-1];

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory self-test sequencer: writes a pattern over [addr_start, addr_end),
// reads it back, compares against the expected values and reports the result.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADD_WIDTH = 10,
  parameter int DAT_WIDTH = 8,
  parameter int RD_LAT    = 1,
  parameter int ERR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 pat_sel,
  input  logic [ADD_WIDTH-1:0] addr_start,
  input  logic [ADD_WIDTH:0]   addr_end,
  output logic [ADD_WIDTH-1:0] add,
  output logic [DAT_WIDTH-1:0] dataW,
  input  logic [DAT_WIDTH-1:0] dataR,
  output logic                 en,
  output logic                 we,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_WIDTH-1:0] err_cnt,
  output logic [ADD_WIDTH-1:0] fail_addr,
  output logic [DAT_WIDTH-1:0] fail_data
);

  localparam logic [ADD_WIDTH:0] ONE        = {{ADD_WIDTH{1'b0}}, 1'b1};
  localparam logic [2:0]         DRAIN_LAST = 3'(RD_LAT);

  // idx+1 formed at ADD_WIDTH+1 bits, then passed through the pattern generator
  // and truncated to the RAM width.
  function automatic logic [DAT_WIDTH-1:0] pat_of(input logic [ADD_WIDTH:0] i,
                                                  input logic           sel);
    logic [ADD_WIDTH:0] p1;
    logic [PAT_W-1:0]   w;
    p1 = i + ONE;
    w  = pattern({{(PAT_W-ADD_WIDTH-1){1'b0}}, p1}, sel);
    return w[DAT_WIDTH-1:0];
  endfunction

  bist_state_e          state_q, state_d;
  logic [ADD_WIDTH:0]   idx_q, idx_d, idx_inc;
  logic [ADD_WIDTH-1:0] start_q, start_d;
  logic [ADD_WIDTH:0]   end_q, end_d;
  logic                 pat_q, pat_d;
  logic [2:0]           drain_q, drain_d;
  logic                 last_idx;

  logic                 en_d, we_d, busy_d, done_d, pass_d;
  logic [ADD_WIDTH-1:0] add_d;
  logic [DAT_WIDTH-1:0] data_w_d;
  logic                 clear_err, push, flush;

  logic                 pipe_valid;
  logic [ADD_WIDTH-1:0] pipe_addr;
  logic [DAT_WIDTH-1:0] pipe_exp;

  assign idx_inc  = idx_q + ONE;
  assign last_idx = (idx_q == (end_q - ONE));

  mem_bist_rd_pipe #(
    .RD_LAT   (RD_LAT),
    .ADD_WIDTH(ADD_WIDTH),
    .DAT_WIDTH(DAT_WIDTH)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_addr(idx_q[ADD_WIDTH-1:0]),
    .push_exp (pat_of(idx_q, pat_q)),
    .out_valid(pipe_valid),
    .out_addr (pipe_addr),
    .out_exp  (pipe_exp)
  );

  // Next-state and next-output logic; every RAM-facing output is registered.
  // NOTE: every variable gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start_d   = start_q;
    end_d     = end_q;
    pat_d     = pat_q;
    drain_d   = drain_q;
    en_d      = 1'b0;
    we_d      = 1'b0;
    add_d     = add;
    data_w_d  = dataW;
    busy_d    = busy;
    done_d    = done;
    pass_d    = pass;
    clear_err = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          start_d   = addr_start;
          end_d     = addr_end;
          pat_d     = pat_sel;
          clear_err = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          if (addr_end <= {1'b0, addr_start}) begin
            // Empty range: report a trivial pass without touching the RAM.
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d  = ST_WRITE;
            idx_d    = {1'b0, addr_start};
            en_d     = 1'b1;
            we_d     = 1'b1;
            add_d    = addr_start;
            data_w_d = pat_of({1'b0, addr_start}, pat_sel);
            busy_d   = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        en_d = 1'b1;
        if (last_idx) begin
          state_d = ST_READ;
          idx_d   = {1'b0, start_q};
          add_d   = start_q;
        end else begin
          idx_d    = idx_inc;
          we_d     = 1'b1;
          add_d    = idx_inc[ADD_WIDTH-1:0];
          data_w_d = pat_of(idx_inc, pat_q);
        end
      end

      ST_READ: begin
        // The read of idx_q is taken by the RAM on this edge; track its expectation.
        push = 1'b1;
        if (last_idx) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          en_d  = 1'b1;
          idx_d = idx_inc;
          add_d = idx_inc[ADD_WIDTH-1:0];
        end
      end

      ST_DRAIN: begin
        // Wait for the final compare to land in err_cnt before reporting.
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt == '0);
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort && busy) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      push    = 1'b0;
      flush   = 1'b1;
    end
  end

  // FSM, sequencing state and registered outputs.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      pat_q   <= 1'b0;
      drain_q <= '0;
      en      <= 1'b0;
      we      <= 1'b0;
      add     <= '0;
      dataW   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      end_q   <= end_d;
      pat_q   <= pat_d;
      drain_q <= drain_d;
      en      <= en_d;
      we      <= we_d;
      add     <= add_d;
      dataW   <= data_w_d;
      busy    <= busy_d;
      done    <= done_d;
      pass    <= pass_d;
    end
  end

  // Compare returned data; saturating error count, first-failure capture.
  // err_cnt==0 doubles as "no failure captured yet" since it never wraps back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (clear_err) begin
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (pipe_valid && (dataR != pipe_exp)) begin
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (err_cnt == '0) begin
        fail_addr <= pipe_addr;
        fail_data <= dataR;
      end
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl: two instances (RD_LAT=1 and RD_LAT=3),
// each driving a behavioural RAM with a matching read latency.
module tb_mem_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3, abort, pat_sel;
  logic [9:0] addr_start;
  logic [10:0] addr_end;
  logic       fault1;

  logic [9:0]  add1, add3, faddr1, faddr3;
  logic [7:0]  dataW1, dataW3, dataR1, dataR3, fdata1, fdata3;
  logic        en1, en3, we1, we3, busy1, busy3, done1, done3, pass1, pass3;
  logic [15:0] err1, err3;

  int total = 0;
  int bad   = 0;
  int cyc;
  int base;

  always #5 clk = ~clk;

  mem_bist_ctrl #(.ADD_WIDTH(10), .DAT_WIDTH(8), .RD_LAT(1), .ERR_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .pat_sel(pat_sel),
    .addr_start(addr_start), .addr_end(addr_end), .add(add1), .dataW(dataW1),
    .dataR(dataR1), .en(en1), .we(we1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_addr(faddr1), .fail_data(fdata1)
  );

  mem_bist_ctrl #(.ADD_WIDTH(10), .DAT_WIDTH(8), .RD_LAT(3), .ERR_WIDTH(16)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort), .pat_sel(pat_sel),
    .addr_start(addr_start), .addr_end(addr_end), .add(add3), .dataW(dataW3),
    .dataR(dataR3), .en(en3), .we(we3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_addr(faddr3), .fail_data(fdata3)
  );

  // Behavioural RAM, 1-cycle read, optional stuck-at-0 on bit 3 at address 0x08.
  logic [7:0] mem1 [1024];
  int         acc1 = 0;
  always @(posedge clk) begin
    logic [7:0] v;
    if (en1) acc1 <= acc1 + 1;
    if (en1 && we1) mem1[add1] <= dataW1;
    if (en1 && !we1) begin
      v = mem1[add1];
      if (fault1 && add1 == 10'h008) v[3] = 1'b0;
      dataR1 <= v;
    end
  end

  // Behavioural RAM, 3-cycle read.
  logic [7:0] mem3 [1024];
  logic [7:0] rd3 [3];
  always @(posedge clk) begin
    if (en3 && we3) mem3[add3] <= dataW3;
    if (en3 && !we3) rd3[0] <= mem3[add3];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign dataR3 = rd3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_start(input bit sel3, input logic [9:0] s, input logic [10:0] e,
                           input logic p);
    addr_start = s;
    addr_end   = e;
    pat_sel    = p;
    if (sel3) start3 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input bit sel3, input int limit, input string tag,
                           output int cycles);
    cycles = 0;
    while (((sel3 ? done3 : done1) == 1'b0) && cycles < limit) begin
      tick();
      cycles++;
    end
    check({tag, "_no_timeout"}, sel3 ? done3 : done1, 1);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; abort = 1'b0; pat_sel = 1'b0;
    addr_start = '0; addr_end = '0; fault1 = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_ctrl1", {en1, we1, busy1, done1, pass1}, 0);
    check("rst_add_data1", {add1, dataW1}, 0);
    check("rst_err1", {err1, faddr1, fdata1}, 0);
    check("rst_ctrl3", {en3, we3, busy3, done3, pass3}, 0);
    rst = 1'b0;
    tick();

    // 1: 0x000..0x100, increment pattern, fault-free
    base = acc1;
    run_start(0, 10'h000, 11'h100, 1'b0);
    check("t1_first_write", {en1, we1, busy1, add1, dataW1}, {3'b111, 10'h000, 8'h01});
    wait_done(0, 600, "t1", cyc);
    check("t1_latency", cyc, 514);
    check("t1_pass", {pass1, busy1, en1}, 3'b100);
    check("t1_err", err1, 0);
    check("t1_accesses", acc1 - base, 512);
    check("t1_mem05", mem1[5], 8'h06);
    check("t1_memFF_trunc", mem1[255], 8'h00);

    // 2: stuck bit at 0x08
    fault1 = 1'b1;
    run_start(0, 10'h000, 11'h100, 1'b0);
    check("t2_done_cleared", done1, 0);
    wait_done(0, 600, "t2", cyc);
    check("t2_err_cnt", err1, 1);
    check("t2_fail_addr", faddr1, 10'h008);
    check("t2_fail_data", fdata1, 8'h01);
    check("t2_pass", pass1, 0);
    fault1 = 1'b0;

    // 3: empty range
    base = acc1;
    run_start(0, 10'h010, 11'h010, 1'b0);
    check("t3_done_pass", {done1, pass1, busy1}, 3'b110);
    check("t3_err_cleared", {err1, faddr1, fdata1}, 0);
    repeat (2) tick();
    check("t3_no_access", acc1 - base, 0);

    // 4: full RAM, inverted pattern
    base = acc1;
    run_start(0, 10'h000, 11'h400, 1'b1);
    check("t4_first_data", dataW1, 8'hFE);
    wait_done(0, 2200, "t4", cyc);
    check("t4_latency", cyc, 2050);
    check("t4_pass", {pass1, err1}, {1'b1, 16'h0000});
    check("t4_accesses", acc1 - base, 2048);
    check("t4_memFF", mem1[255], 8'hFF);
    check("t4_mem3FF", mem1[1023], 8'hFF);
    check("t4_mem000", mem1[0], 8'hFE);

    // 5: abort during WRITE at idx 0x40
    run_start(0, 10'h000, 11'h100, 1'b0);
    repeat (64) tick();
    check("t5_at_0x40", {en1, we1, add1, dataW1}, {2'b11, 10'h040, 8'h41});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_outs", {en1, we1, busy1, done1}, 0);
    base = acc1;
    repeat (2) tick();
    check("t5_idle_after_abort", acc1 - base, 0);
    addr_start = 10'h000; addr_end = 11'h100; start1 = 1'b1; abort = 1'b1;
    tick();
    start1 = 1'b0; abort = 1'b0;
    check("t5_abort_beats_start", {busy1, en1, done1}, 0);
    run_start(0, 10'h000, 11'h100, 1'b0);
    repeat (10) tick();
    addr_end = 11'h020; start1 = 1'b1;
    tick();
    start1 = 1'b0; addr_end = 11'h100;
    wait_done(0, 600, "t5", cyc);
    check("t5_start_ignored_latency", cyc + 11, 514);
    check("t5_pass", pass1, 1);

    // 6: reset during READ, then RD_LAT=3 instance runs test 1
    run_start(0, 10'h000, 11'h100, 1'b0);
    repeat (300) tick();
    check("t6_in_read", {en1, we1}, 2'b10);
    rst = 1'b1;
    #1;
    check("t6_rst_ctrl", {en1, we1, busy1, done1, pass1}, 0);
    check("t6_rst_add_data", {add1, dataW1}, 0);
    base = acc1;
    repeat (2) tick();
    check("t6_no_access", acc1 - base, 0);
    rst = 1'b0;
    tick();
    run_start(1, 10'h000, 11'h100, 1'b0);
    wait_done(1, 700, "t6", cyc);
    check("t6_lat3_latency", cyc, 516);
    check("t6_lat3_pass", {pass3, err3}, {1'b1, 16'h0000});
    check("t6_lat3_mem05", mem3[5], 8'h06);
    check("t6_dut1_idle", {busy1, done1, en1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
